// File: rtl/vid_capture_quant.sv
// Capture stage from the RGB video input pins to the VRAM write port: tracks the active-video
// position, quantises 4-bit grey to a 2-bit DMG shade (optional 2x2 ordered dither), and writes one word per in-window pixel.
module vid_capture_quant #(
    parameter int H_ACTIVE = 160,
    parameter int V_ACTIVE = 144,
    parameter bit INVERT   = 1'b0
) (
    input  logic        rgb_clk,
    input  logic        rst,
    input  logic        rgb_de,
    input  logic        rgb_vsync,
    input  logic [3:0]  rgb_data,
    input  logic        do_dither,
    output logic [15:0] vramaddr,
    output logic [1:0]  vramdata,
    output logic        vramwe,
    output logic        vramclk
);

    localparam logic [8:0] H_LIM = 9'(H_ACTIVE);
    localparam logic [8:0] V_LIM = 9'(V_ACTIVE);

    logic [7:0] x;
    logic [7:0] y;
    logic       de_d;
    logic       vs_d;
    logic       frame_ok;

    logic       de_fall;
    logic       vs_rise;
    logic       wr_en;
    logic [1:0] thr;
    logic [2:0] s_q;
    logic [1:0] q;
    logic [1:0] shade;

    assign vramclk = rgb_clk;

    always_comb begin
        de_fall = de_d & ~rgb_de;
        vs_rise = ~vs_d & rgb_vsync;
        // A vsync edge restarts the frame, so the pixel coinciding with it is never written.
        wr_en   = rgb_de & frame_ok & ~vs_rise
                & ({1'b0, x} < H_LIM) & ({1'b0, y} < V_LIM);

        case ({y[0], x[0]})
            2'b00:   thr = 2'd0;
            2'b01:   thr = 2'd2;
            2'b10:   thr = 2'd3;
            default: thr = 2'd1;
        endcase

        s_q = 3'(({1'b0, rgb_data} + {3'b000, thr}) >> 2);
        if (do_dither) begin
            q = s_q[2] ? 2'd3 : s_q[1:0];
        end else begin
            q = rgb_data[3:2];
        end
        shade = INVERT ? ~q : q;
    end

    // NOTE: every register here uses non-blocking assignments so all of them sample pre-edge values.
    always_ff @(posedge rgb_clk) begin
        if (rst) begin
            x        <= 8'd0;
            y        <= 8'd0;
            de_d     <= 1'b0;
            vs_d     <= 1'b0;
            frame_ok <= 1'b0;
            vramaddr <= 16'd0;
            vramdata <= 2'd0;
            vramwe   <= 1'b0;
        end else begin
            de_d   <= rgb_de;
            vs_d   <= rgb_vsync;
            vramwe <= wr_en;
            if (wr_en) begin
                vramaddr <= {y, x};
                vramdata <= shade;
            end

            if (vs_rise) begin
                x        <= 8'd0;
                y        <= 8'd0;
                frame_ok <= 1'b1;
            end else if (de_fall) begin
                x <= 8'd0;
                y <= (y == 8'hFF) ? y : y + 8'd1;
            end else if (rgb_de) begin
                x <= (x == 8'hFF) ? x : x + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vid_capture_quant.sv
// Randomised and directed bench for vid_capture_quant; a normal and an INVERT=1 instance share
// stimulus and are compared every cycle against a behavioural pixel/frame model.
module tb_vid_capture_quant;

    localparam int BAYER [2][2] = '{'{0, 2}, '{3, 1}};

    logic        rgb_clk = 1'b0;
    logic        rst;
    logic        rgb_de;
    logic        rgb_vsync;
    logic [3:0]  rgb_data;
    logic        do_dither;
    logic [15:0] vramaddr,  vramaddr_i;
    logic [1:0]  vramdata,  vramdata_i;
    logic        vramwe,    vramwe_i;
    logic        vramclk,   vramclk_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_x, m_y;
    bit m_de_d, m_vs_d, m_fok;
    bit e_we;
    int e_addr, e_data, e_data_inv;

    // Write statistics gathered from the normal instance
    int wr_cnt, first_a, last_a, max_lo, max_hi;

    vid_capture_quant u_dut (
        .rgb_clk   (rgb_clk),
        .rst       (rst),
        .rgb_de    (rgb_de),
        .rgb_vsync (rgb_vsync),
        .rgb_data  (rgb_data),
        .do_dither (do_dither),
        .vramaddr  (vramaddr),
        .vramdata  (vramdata),
        .vramwe    (vramwe),
        .vramclk   (vramclk)
    );

    vid_capture_quant #(.INVERT(1'b1)) u_dut_inv (
        .rgb_clk   (rgb_clk),
        .rst       (rst),
        .rgb_de    (rgb_de),
        .rgb_vsync (rgb_vsync),
        .rgb_data  (rgb_data),
        .do_dither (do_dither),
        .vramaddr  (vramaddr_i),
        .vramdata  (vramdata_i),
        .vramwe    (vramwe_i),
        .vramclk   (vramclk_i)
    );

    always #5 rgb_clk = ~rgb_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int quant(input int data, input bit dith, input int px, input int py);
        int v;
        if (dith) begin
            v = (data + BAYER[py % 2][px % 2]) / 4;
            return (v > 3) ? 3 : v;
        end
        return data / 4;
    endfunction

    task automatic clear_stats();
        wr_cnt  = 0;
        first_a = -1;
        last_a  = -1;
        max_lo  = 0;
        max_hi  = 0;
    endtask

    // One pixel clock: drive inputs, advance the model, then compare both instances after the edge.
    task automatic step(input bit r, input bit de, input bit vs, input int data, input bit dith);
        bit vsr, def, wr;
        int q;
        rst       = r;
        rgb_de    = de;
        rgb_vsync = vs;
        rgb_data  = 4'(data);
        do_dither = dith;

        if (r) begin
            m_x = 0; m_y = 0; m_de_d = 0; m_vs_d = 0; m_fok = 0;
            e_we = 0; e_addr = 0; e_data = 0; e_data_inv = 0;
        end else begin
            vsr = vs && !m_vs_d;
            def = m_de_d && !de;
            wr  = de && m_fok && !vsr && (m_x < 160) && (m_y < 144);
            e_we = wr;
            if (wr) begin
                q          = quant(data, dith, m_x, m_y);
                e_addr     = m_y * 256 + m_x;
                e_data     = q;
                e_data_inv = 3 - q;
            end
            if (vsr) begin
                m_x = 0; m_y = 0; m_fok = 1;
            end else if (def) begin
                m_x = 0;
                m_y = (m_y >= 255) ? 255 : m_y + 1;
            end else if (de) begin
                m_x = (m_x >= 255) ? 255 : m_x + 1;
            end
            m_de_d = de;
            m_vs_d = vs;
        end

        @(posedge rgb_clk);
        #1;
        check("we",       vramwe,     e_we);
        check("addr",     vramaddr,   e_addr);
        check("data",     vramdata,   e_data);
        check("we_inv",   vramwe_i,   e_we);
        check("addr_inv", vramaddr_i, e_addr);
        check("data_inv", vramdata_i, e_data_inv);

        if (vramwe === 1'b1) begin
            if (wr_cnt == 0) first_a = int'(vramaddr);
            last_a = int'(vramaddr);
            wr_cnt++;
            if (int'(vramaddr[7:0])  > max_lo) max_lo = int'(vramaddr[7:0]);
            if (int'(vramaddr[15:8]) > max_hi) max_hi = int'(vramaddr[15:8]);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic vsync_pulse();
        step(1'b0, 1'b0, 1'b1, 0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 0, 1'b0);
        idle(2);
    endtask

    // data < 0 selects a random grey level per pixel
    task automatic line(input int npix, input int data, input bit dith);
        for (int i = 0; i < npix; i++) begin
            step(1'b0, 1'b1, 1'b0, (data < 0) ? int'($urandom_range(0, 15)) : data, dith);
        end
        idle(4);
    endtask

    initial begin
        bit de_r;

        // Reset with activity on the inputs
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'($urandom_range(0, 1)), 1'b0, int'($urandom_range(0, 15)), 1'b0);
        end
        check("rst_we",   vramwe,   0);
        check("rst_addr", vramaddr, 0);
        check("vramclk",  vramclk,  1);

        // No vsync yet: nothing may be written
        clear_stats();
        repeat (3) line(160, 15, 1'b0);
        check("novs_writes", wr_cnt, 0);

        // Full white frame, plain truncation
        vsync_pulse();
        clear_stats();
        repeat (144) line(160, 15, 1'b0);
        check("frame_count", wr_cnt,  23040);
        check("frame_first", first_a, 0);
        check("frame_last",  last_a,  32'h8F9F);

        // Dither patterns on short lines
        vsync_pulse(); repeat (2) line(8, 5, 1'b1);
        vsync_pulse(); repeat (2) line(8, 6, 1'b1);
        vsync_pulse(); repeat (2) line(8, 15, 1'b1);
        vsync_pulse(); repeat (2) line(8, 0, 1'b1);

        // Dither toggled mid-line
        vsync_pulse();
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 6, (i % 3) == 0);
        idle(4);

        // Window clip: 200x150 random frame
        vsync_pulse();
        clear_stats();
        repeat (150) line(200, -1, 1'b1);
        check("clip_count", wr_cnt, 23040);
        check("clip_x",     max_lo < 160, 1);
        check("clip_y",     max_hi < 144, 1);

        // Line longer than 255 pixels, then more than 255 lines
        vsync_pulse(); line(300, 7, 1'b0);
        vsync_pulse(); repeat (260) line(2, 9, 1'b0);

        // Vsync rising at x=80 of line 10
        vsync_pulse();
        repeat (10) line(160, -1, 1'b0);
        for (int i = 0; i < 80; i++) step(1'b0, 1'b1, 1'b0, int'($urandom_range(0, 15)), 1'b0);
        step(1'b0, 1'b1, 1'b1, 12, 1'b0);
        check("vs_cycle_we", vramwe, 0);
        clear_stats();
        for (int i = 0; i < 79; i++) step(1'b0, 1'b1, 1'b1, int'($urandom_range(0, 15)), 1'b0);
        idle(4);
        check("vs_mid_first", first_a, 0);

        // de fall and vsync rise in the same cycle: row stays 0
        vsync_pulse();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 10, 1'b0);
        step(1'b0, 1'b0, 1'b1, 0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 0, 1'b0);
        idle(2);
        clear_stats();
        line(4, 3, 1'b0);
        check("same_cycle_first", first_a, 0);

        // Reset mid-line: no writes until the next vsync
        vsync_pulse();
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 8, 1'b0);
        step(1'b1, 1'b1, 1'b0, 8, 1'b0);
        check("midrst_we", vramwe, 0);
        clear_stats();
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 8, 1'b0);
        idle(4);
        check("midrst_writes", wr_cnt, 0);

        // Random traffic
        vsync_pulse();
        de_r = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) de_r = ~de_r;
            step($urandom_range(0, 999) == 0, de_r, $urandom_range(0, 299) == 0,
                 int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
